// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: machine-level interrupt controller.
// Latches platform interrupt edges into mip[25:16], tracks level MEI/MSI/MTI,
// arbitrates enabled pending sources by fixed priority and holds a single
// trap request towards the core until it is acknowledged.
// Optional build macro: INTC_IRQ_SYNC_EN adds a 2-flop input synchronizer
// on every interrupt source (all latencies grow by two cycles).
module interrupt_ctrl #(
   parameter int unsigned PLAT_IRQ_LO = 16,
   parameter int unsigned PLAT_IRQ_N  = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [PLAT_IRQ_N-1:0] irq_plat,
   input  logic                  irq_mei,
   input  logic                  irq_msi,
   input  logic                  irq_mti,
   input  logic [31:0]           mie,
   input  logic                  gie,
   input  logic                  mip_wr_en,
   input  logic [31:0]           mip_wr_data,
   output logic [31:0]           mip,
   output logic                  trap_req,
   output logic [4:0]            trap_code,
   input  logic                  trap_ack
);

   localparam int unsigned CODE_W = 5;
   localparam int unsigned SRC_W  = PLAT_IRQ_N + 3;
   localparam int unsigned MEI_B  = 11;
   localparam int unsigned MSI_B  = 3;
   localparam int unsigned MTI_B  = 7;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic                req_q, req_d;
   logic [CODE_W-1:0]   code_q, code_d;

   logic [SRC_W-1:0]      src_raw, src;
   logic [PLAT_IRQ_N-1:0] plat, prev, pend, rise, clr;
   logic                  mei_q, msi_q, mti_q;
   logic [31:0]           eligible;
   logic                  win_valid;
   logic [CODE_W-1:0]     win_code;
   logic                  unused_bits;

   assign src_raw = {irq_mti, irq_msi, irq_mei, irq_plat};

`ifdef INTC_IRQ_SYNC_EN
   logic [SRC_W-1:0] sync1, sync2;

   // Two-flop synchronizer for all asynchronous interrupt sources
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= src_raw;
         sync2 <= sync1;
      end
   end

   assign src = sync2;
`else
   assign src = src_raw;
`endif

   assign plat = src[PLAT_IRQ_N-1:0];
   assign rise = plat & ~prev;

   // Platform pending clears: software write of 0, or ack of the matching code
   always_comb begin
      clr = '0;
      if (mip_wr_en) begin
         clr = ~mip_wr_data[PLAT_IRQ_LO +: PLAT_IRQ_N];
      end
      if (state_q == REQ && trap_ack) begin
         for (int i = 0; i < int'(PLAT_IRQ_N); i++) begin
            if (code_q == CODE_W'(PLAT_IRQ_LO + 32'(i))) begin
               clr[i] = 1'b1;
            end
         end
      end
   end

   // Edge history, platform pending latch (set wins over clear), level capture
   always_ff @(posedge clk) begin
      if (rst) begin
         prev  <= '0;
         pend  <= '0;
         mei_q <= 1'b0;
         msi_q <= 1'b0;
         mti_q <= 1'b0;
      end else begin
         prev  <= plat;
         pend  <= (pend & ~clr) | rise;
         mei_q <= src[PLAT_IRQ_N];
         msi_q <= src[PLAT_IRQ_N + 1];
         mti_q <= src[PLAT_IRQ_N + 2];
      end
   end

   // mip view of the pending registers; reserved bits read 0
   always_comb begin
      mip                            = '0;
      mip[MEI_B]                     = mei_q;
      mip[MSI_B]                     = msi_q;
      mip[MTI_B]                     = mti_q;
      mip[PLAT_IRQ_LO +: PLAT_IRQ_N] = pend;
   end

   assign eligible = mip & mie & {32{gie}};

   // Fixed priority: MEI, MSI, MTI, then platform with lowest code first
   always_comb begin
      win_valid = 1'b0;
      win_code  = '0;
      for (int i = int'(PLAT_IRQ_N) - 1; i >= 0; i--) begin
         if (eligible[PLAT_IRQ_LO + 32'(i)]) begin
            win_valid = 1'b1;
            win_code  = CODE_W'(PLAT_IRQ_LO + 32'(i));
         end
      end
      if (eligible[MTI_B]) begin
         win_valid = 1'b1;
         win_code  = CODE_W'(MTI_B);
      end
      if (eligible[MSI_B]) begin
         win_valid = 1'b1;
         win_code  = CODE_W'(MSI_B);
      end
      if (eligible[MEI_B]) begin
         win_valid = 1'b1;
         win_code  = CODE_W'(MEI_B);
      end
   end

   // Request FSM state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         code_q  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         code_q  <= code_d;
      end
   end

   // Next state: capture winner in IDLE, hold request frozen until ack
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      code_d  = code_q;
      case (state_q)
         IDLE: begin
            if (win_valid) begin
               state_d = REQ;
               req_d   = 1'b1;
               code_d  = win_code;
            end
         end
         REQ: begin
            if (trap_ack) begin
               state_d = IDLE;
               req_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   assign trap_req  = req_q;
   assign trap_code = code_q;

   // Write-data and eligible bits outside the implemented fields are don't-care
   assign unused_bits = ^{mip_wr_data, eligible};

endmodule
